// File: rtl/xsleenacore_mixer_pkg.sv
// Shared types, defaults and elaboration helpers for the layer mixer slice.
package xsleenacore_mixer_pkg;

  localparam int DEF_NUM_LAYERS = 4;
  localparam int DEF_COL_W      = 7;
  localparam int DEF_PRI_W      = 3;
  localparam int DEF_CH_W       = 4;
  localparam int DEF_WQ_DEPTH   = 4;

  // Queue entries are sized for the widest legal configuration.
  localparam int WQ_BANK_W = 2;
  localparam int WQ_IDX_W  = 16;

  typedef struct packed {
    logic [WQ_BANK_W-1:0] bank;
    logic [WQ_IDX_W-1:0]  index;
    logic [7:0]           data;
  } wq_entry_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/xsleenacore_wr_queue.sv
// Small synchronous FIFO buffering posted palette writes until blanking.
module xsleenacore_wr_queue
  import xsleenacore_mixer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [W-1:0]  mem [0:DEPTH-1];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt, cnt_nxt;
  logic          push_ok, pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign empty   = (cnt == '0);
  assign dout    = mem[rp];

  always_comb begin
    cnt_nxt = cnt;
    case ({push_ok, pop_ok})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      full <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      cnt  <= cnt_nxt;
      full <= (cnt_nxt == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= din;

endmodule

// File: rtl/xsleenacore_layer_mixer.sv
// Priority-PROM layer select, palette lookup and registered RGB; CPU palette
// writes are queued and only land in the palette while the output is blanked.
module xsleenacore_layer_mixer
  import xsleenacore_mixer_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int COL_W      = DEF_COL_W,
  parameter int PRI_W      = DEF_PRI_W,
  parameter int CH_W       = DEF_CH_W,
  parameter int WQ_DEPTH   = DEF_WQ_DEPTH,
  localparam int SEL_W     = clog2(NUM_LAYERS),
  localparam int PAL_AW    = SEL_W + COL_W,
  localparam int NBANK     = ceil_div(3*CH_W, 8),
  localparam int BANK_W    = clog2(NBANK)
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pix_ce,
  input  logic                        blank_n,
  input  logic [NUM_LAYERS*COL_W-1:0] layer_col,
  input  logic [PRI_W-1:0]            pri,
  input  logic                        prom_wr,
  input  logic [PRI_W+NUM_LAYERS-1:0] prom_addr,
  input  logic [SEL_W-1:0]            prom_data,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [BANK_W+PAL_AW-1:0]    cpu_addr,
  input  logic [7:0]                  cpu_din,
  output logic                        cpu_ack,
  output logic [7:0]                  cpu_dout,
  output logic                        wq_full,
  output logic [CH_W-1:0]             video_r,
  output logic [CH_W-1:0]             video_g,
  output logic [CH_W-1:0]             video_b
);
  localparam int WORD_W  = 3*CH_W;
  localparam int RAM_W   = NBANK*8;
  localparam int PROM_AW = PRI_W + NUM_LAYERS;
  localparam int STAGES  = 3;
  // Bits of the byte view that lie above the colour word read back as 1.
  localparam logic [RAM_W-1:0] PAD = {RAM_W{1'b1}} << WORD_W;

  if (NUM_LAYERS < 2 || NUM_LAYERS > 8) begin : g_bad_layers
    $error("NUM_LAYERS must be in 2..8");
  end
  if (CH_W < 4 || CH_W > 8) begin : g_bad_ch
    $error("CH_W must be in 4..8");
  end
  if (WQ_DEPTH < 1 || (WQ_DEPTH & (WQ_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("WQ_DEPTH must be a power of 2");
  end
  if (COL_W < 4 || PAL_AW > WQ_IDX_W) begin : g_bad_col
    $error("COL_W out of range");
  end

  logic [NUM_LAYERS-1:0][COL_W-1:0] col_s0, col_s1;
  logic [PRI_W-1:0]      pri_s0;
  logic [NUM_LAYERS-1:0] t_s0;
  logic [SEL_W-1:0]      sel_s1;
  logic [PAL_AW-1:0]     idx_s2;
  logic [WORD_W-1:0]     pal_q;
  logic [STAGES:0]       vld_pipe;
  logic                  blank_d;

  logic [SEL_W-1:0] prom [0:(1<<PROM_AW)-1];
  logic [RAM_W-1:0] pal  [0:(1<<PAL_AW)-1];

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_lane
    assign t_s0[i] = (col_s0[i][3:0] == 4'd0);
  end

  always_ff @(posedge clk) begin
    col_s0 <= layer_col;
    pri_s0 <= pri;
    sel_s1 <= prom[{pri_s0, t_s0}];
    col_s1 <= col_s0;
    idx_s2 <= {sel_s1, col_s1[sel_s1]};
    if (prom_wr) prom[prom_addr] <= prom_data;
  end

  // blank_n rides alongside the pixel data so blank_d lines up with pal_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:0], blank_n};
  end
  assign blank_d = vld_pipe[STAGES];

  wq_entry_t         wq_in, wq_out;
  logic              wq_push, wq_pop, wq_empty, drain_we, rd_issue, rd_p1;
  logic [BANK_W-1:0] cpu_bank, rd_bank;
  logic [PAL_AW-1:0] cpu_idx;
  logic [RAM_W-1:0]  rd_word, rd_full;
  logic [7:0]        rd_byte;

  assign cpu_bank = cpu_addr[BANK_W+PAL_AW-1 -: BANK_W];
  assign cpu_idx  = cpu_addr[PAL_AW-1:0];
  // A held request must not be served twice while its ack is still up.
  assign wq_push  = cpu_req & cpu_we & ~wq_full & ~cpu_ack;
  assign wq_pop   = ~blank_d & ~wq_empty;
  assign rd_issue = cpu_req & ~cpu_we & ~blank_d & wq_empty & ~rd_p1 & ~cpu_ack;
  assign drain_we = wq_pop && (32'(wq_out.index) < 32'(1 << PAL_AW));

  always_comb begin
    wq_in       = '0;
    wq_in.bank  = WQ_BANK_W'(cpu_bank);
    wq_in.index = WQ_IDX_W'(cpu_idx);
    wq_in.data  = cpu_din;
  end

  xsleenacore_wr_queue #(.DEPTH(WQ_DEPTH), .W($bits(wq_entry_t))) u_wq (
    .clk   (clk),
    .rst   (rst),
    .push  (wq_push),
    .pop   (wq_pop),
    .din   (wq_in),
    .dout  (wq_out),
    .full  (wq_full),
    .empty (wq_empty)
  );

  always_ff @(posedge clk) begin
    pal_q   <= pal[idx_s2][WORD_W-1:0];
    rd_word <= pal[cpu_idx];
    for (int b = 0; b < NBANK; b++)
      if (drain_we && wq_out.bank == WQ_BANK_W'(b))
        pal[wq_out.index[PAL_AW-1:0]][8*b +: 8] <= wq_out.data;
  end

  always_comb begin
    rd_full = rd_word | PAD;
    rd_byte = 8'hFF;
    for (int b = 0; b < NBANK; b++)
      if (rd_bank == BANK_W'(b)) rd_byte = rd_full[8*b +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_p1    <= 1'b0;
      rd_bank  <= '0;
      cpu_ack  <= 1'b0;
      cpu_dout <= 8'hFF;
    end else begin
      rd_p1   <= rd_issue;
      cpu_ack <= wq_push | rd_p1;
      if (rd_issue) rd_bank  <= cpu_bank;
      if (rd_p1)    cpu_dout <= rd_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         {video_b, video_g, video_r} <= '0;
    else if (pix_ce) {video_b, video_g, video_r} <= blank_d ? pal_q : '0;
  end

endmodule

// File: tb/tb_xsleenacore_layer_mixer.sv
// Directed bench: 8 layers, 4-bit channels, 4-deep write queue.
module tb_xsleenacore_layer_mixer;
  localparam int NL = 8, COL_W = 7, PRI_W = 3, CH_W = 4, WQ_DEPTH = 4;
  localparam logic [9:0] IDX_A = {3'd1, 7'h15};
  localparam logic [9:0] IDX_B = {3'd6, 7'h23};

  logic                  clk = 1'b0;
  logic                  rst, pix_ce, blank_n;
  logic [NL*COL_W-1:0]   layer_col;
  logic [PRI_W-1:0]      pri;
  logic                  prom_wr;
  logic [PRI_W+NL-1:0]   prom_addr;
  logic [2:0]            prom_data;
  logic                  cpu_req, cpu_we;
  logic [10:0]           cpu_addr;
  logic [7:0]            cpu_din;
  logic                  cpu_ack;
  logic [7:0]            cpu_dout;
  logic                  wq_full;
  logic [CH_W-1:0]       video_r, video_g, video_b;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  xsleenacore_layer_mixer #(.NUM_LAYERS(NL), .COL_W(COL_W), .PRI_W(PRI_W),
                            .CH_W(CH_W), .WQ_DEPTH(WQ_DEPTH)) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .blank_n(blank_n),
    .layer_col(layer_col), .pri(pri), .prom_wr(prom_wr),
    .prom_addr(prom_addr), .prom_data(prom_data), .cpu_req(cpu_req),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout), .wq_full(wq_full),
    .video_r(video_r), .video_g(video_g), .video_b(video_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // pri 5 picks the highest opaque layer, every other mode the lowest.
  function automatic logic [2:0] prom_sel(input logic [10:0] a);
    logic [2:0] s;
    s = 3'd0;
    if (a[10:8] == 3'd5) begin
      for (int i = 0; i < NL; i++) if (!a[i]) s = i[2:0];
    end else begin
      for (int i = NL-1; i >= 0; i--) if (!a[i]) s = i[2:0];
    end
    return s;
  endfunction

  task automatic set_layers(input logic [6:0] l1, input logic [6:0] l6);
    layer_col = '0;
    layer_col[1*COL_W +: COL_W] = l1;
    layer_col[6*COL_W +: COL_W] = l6;
  endtask

  task automatic cpu_write(input logic b, input logic [9:0] idx, input logic [7:0] d,
                           input string tag);
    bit got;
    got = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = {b, idx}; cpu_din = d;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cpu_ack) begin got = 1'b1; break; end
    end
    chk(tag, 32'(got), 32'd1);
    cpu_req = 1'b0;
  endtask

  task automatic cpu_read(input logic b, input logic [9:0] idx, input logic [7:0] exp,
                          input string tag);
    bit got;
    got = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = {b, idx};
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cpu_ack) begin got = 1'b1; break; end
    end
    chk({tag, "_ack"}, 32'(got), 32'd1);
    chk(tag, 32'(cpu_dout), 32'(exp));
    cpu_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    bit got;
    rst = 1'b1; pix_ce = 1'b1; blank_n = 1'b0; layer_col = '0; pri = '0;
    prom_wr = 1'b0; prom_addr = '0; prom_data = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    tick(3);
    chk("rst_video", 32'({video_b, video_g, video_r}), 32'h0);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_dout", 32'(cpu_dout), 32'hFF);
    chk("rst_full", 32'(wq_full), 32'd0);
    rst = 1'b0;

    for (int a = 0; a < (1 << (PRI_W+NL)); a++) begin
      @(negedge clk);
      prom_wr = 1'b1; prom_addr = a[10:0]; prom_data = prom_sel(a[10:0]);
    end
    @(negedge clk); prom_wr = 1'b0;

    // Palette entries A = 12'hABC, B = 12'h5E7, loaded while blanked.
    cpu_write(1'b0, IDX_A, 8'hBC, "wr_a0");
    cpu_write(1'b1, IDX_A, 8'h0A, "wr_a1");
    cpu_write(1'b0, IDX_B, 8'hE7, "wr_b0");
    cpu_write(1'b1, IDX_B, 8'h05, "wr_b1");
    set_layers(7'h15, 7'h00); pri = 3'd0;
    tick(8);
    chk("blank_zero", 32'({video_b, video_g, video_r}), 32'h0);

    blank_n = 1'b1;
    tick(4);
    chk("lat_pre", 32'({video_b, video_g, video_r}), 32'h0);
    tick(1);
    chk("lat_post", 32'({video_b, video_g, video_r}), 32'hABC);
    chk("video_b", 32'(video_b), 32'hA);

    set_layers(7'h15, 7'h23); pri = 3'd5;
    tick(6);
    chk("pri5_sel6", 32'({video_b, video_g, video_r}), 32'h5E7);
    pri = 3'd0;
    tick(6);
    chk("pri0_sel1", 32'({video_b, video_g, video_r}), 32'hABC);
    pix_ce = 1'b0; pri = 3'd5;
    tick(6);
    chk("ce_hold", 32'({video_b, video_g, video_r}), 32'hABC);
    pix_ce = 1'b1;
    tick(2);
    chk("ce_load", 32'({video_b, video_g, video_r}), 32'h5E7);
    pri = 3'd0;
    tick(6);

    // Fill the queue during active display; the fifth write must stall.
    cpu_write(1'b0, 10'd5, 8'h3C, "q_wr1");
    cpu_write(1'b1, 10'd5, 8'h07, "q_wr2");
    cpu_write(1'b0, 10'd9, 8'h11, "q_wr3");
    cpu_write(1'b0, 10'd9, 8'h22, "q_wr4");
    chk("wq_full_set", 32'(wq_full), 32'd1);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = {1'b0, 10'd10}; cpu_din = 8'h5A;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    chk("stall_no_ack", 32'(acks), 32'd0);
    chk("stall_full", 32'(wq_full), 32'd1);
    chk("no_glitch", 32'({video_b, video_g, video_r}), 32'hABC);
    blank_n = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cpu_ack) begin got = 1'b1; break; end
    end
    chk("q_wr5", 32'(got), 32'd1);
    cpu_req = 1'b0;
    tick(6);
    chk("blank_video", 32'({video_b, video_g, video_r}), 32'h0);
    cpu_read(1'b0, 10'd5, 8'h3C, "rd_b0_5");
    cpu_read(1'b1, 10'd5, 8'hF7, "rd_b1_pad");
    cpu_read(1'b0, 10'd9, 8'h22, "rd_order");
    cpu_read(1'b0, 10'd10, 8'h5A, "rd_stalled");

    // A read behind a queued write waits for blanking and sees the new data.
    blank_n = 1'b1;
    tick(6);
    cpu_write(1'b0, 10'd12, 8'hC3, "wr_c");
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = {1'b0, 10'd12};
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    chk("rd_wait_active", 32'(acks), 32'd0);
    blank_n = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cpu_ack) begin got = 1'b1; break; end
    end
    chk("rd_blank_ack", 32'(got), 32'd1);
    chk("rd_blank_data", 32'(cpu_dout), 32'hC3);
    cpu_req = 1'b0;

    // Reset with writes pending drops them.
    blank_n = 1'b1;
    tick(6);
    chk("pre_rst_video", 32'({video_b, video_g, video_r}), 32'hABC);
    cpu_write(1'b0, 10'd5, 8'h99, "rq_wr1");
    cpu_write(1'b1, IDX_A, 8'h0F, "rq_wr2");
    cpu_write(1'b0, IDX_A, 8'h00, "rq_wr3");
    chk("rq_not_full", 32'(wq_full), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_video", 32'({video_b, video_g, video_r}), 32'h0);
    chk("mid_rst_full", 32'(wq_full), 32'd0);
    chk("mid_rst_dout", 32'(cpu_dout), 32'hFF);
    rst = 1'b0;
    tick(8);
    chk("post_rst_video", 32'({video_b, video_g, video_r}), 32'hABC);
    blank_n = 1'b0;
    tick(6);
    cpu_read(1'b0, 10'd5, 8'h3C, "rd_dropped");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
